// File: rtl/crossing_ctrl.sv
// crossing_ctrl: multi-phase traffic light sequencer with pedestrian walk slot.
// Define CROSSING_CTRL_FLASH_EN to build the night flashing-yellow mode.
module crossing_ctrl #(
    parameter int C_PHASES     = 2,
    parameter int C_INT_GREEN  = 10,
    parameter int C_INT_YELLOW = 2,
    parameter int C_INT_CLEAR  = 1,
    parameter int C_INT_WALK   = 5,
    parameter int C_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inTick,
    input  logic                  inMode,
    input  logic [C_PHASES-1:0]   inPedestrian,
    output logic [2*C_PHASES-1:0] outLight,
    output logic [C_PHASES-1:0]   outWalk,
    output logic [1:0]            outPhase,
    output logic [C_PHASES-1:0]   outPending
);

    typedef enum logic [2:0] {
        S_GREEN,
        S_YELLOW,
        S_CLEAR,
        S_WALK
`ifdef CROSSING_CTRL_FLASH_EN
        , S_FLASH
`endif
    } state_t;

    localparam logic [1:0] L_OFF    = 2'd0;
    localparam logic [1:0] L_RED    = 2'd1;
    localparam logic [1:0] L_GRN    = 2'd2;
    localparam logic [1:0] L_YEL    = 2'd3;
    localparam logic [1:0] LAST_PH  = 2'(C_PHASES - 1);

    // A zero interval behaves like a one-tick interval
    function automatic logic [C_CNT_W-1:0] loadVal(input int iv);
        return (iv <= 1) ? '0 : C_CNT_W'(iv - 1);
    endfunction

    localparam logic [C_CNT_W-1:0] LD_GREEN  = loadVal(C_INT_GREEN);
    localparam logic [C_CNT_W-1:0] LD_YELLOW = loadVal(C_INT_YELLOW);
    localparam logic [C_CNT_W-1:0] LD_CLEAR  = loadVal(C_INT_CLEAR);
    localparam logic [C_CNT_W-1:0] LD_WALK   = loadVal(C_INT_WALK);

    state_t               state, stateNext;
    logic [C_CNT_W-1:0]   cnt, cntNext;
    logic [1:0]           phase, phaseNext, phaseInc;
    logic                 first, firstNext;
    logic [C_PHASES-1:0]  pedPrev, rise;
    logic [C_PHASES-1:0]  pendNext;
    logic [C_PHASES-1:0]  walkSnap, snapNext;
    logic [2*C_PHASES-1:0] lightNext;
    logic [C_PHASES-1:0]  walkNext;
    logic                 modeEff;

`ifdef CROSSING_CTRL_FLASH_EN
    logic flash, flashNext;
    assign modeEff = inMode;
`else
    logic unusedMode;
    assign unusedMode = inMode;
    assign modeEff    = 1'b0;
`endif

    assign rise = inPedestrian & ~pedPrev;

    // After reset or flash exit the rotation restarts at phase 0
    assign phaseInc = first ? 2'd0 :
                      (phase == LAST_PH) ? 2'd0 : phase + 2'd1;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        phaseNext = phase;
        firstNext = first;
        pendNext  = outPending | rise;
        snapNext  = walkSnap;
`ifdef CROSSING_CTRL_FLASH_EN
        flashNext = flash;
`endif
        if (inTick) begin
            unique case (state)
                S_GREEN: begin
                    if (cnt == '0 || modeEff) begin
                        stateNext = S_YELLOW;
                        cntNext   = LD_YELLOW;
                    end else begin
                        cntNext = cnt - 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (cnt == '0) begin
                        stateNext = S_CLEAR;
                        cntNext   = LD_CLEAR;
                    end else begin
                        cntNext = cnt - 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt != '0) begin
                        cntNext = cnt - 1'b1;
`ifdef CROSSING_CTRL_FLASH_EN
                    end else if (modeEff) begin
                        stateNext = S_FLASH;
                        flashNext = 1'b1;
`endif
                    end else if (outPending != '0) begin
                        stateNext = S_WALK;
                        cntNext   = LD_WALK;
                        snapNext  = outPending | rise;
                        pendNext  = '0;
                    end else begin
                        stateNext = S_GREEN;
                        cntNext   = LD_GREEN;
                        phaseNext = phaseInc;
                        firstNext = 1'b0;
                    end
                end
                S_WALK: begin
                    if (cnt == '0) begin
                        stateNext = S_GREEN;
                        cntNext   = LD_GREEN;
                        phaseNext = phaseInc;
                        firstNext = 1'b0;
                    end else begin
                        cntNext = cnt - 1'b1;
                    end
                end
`ifdef CROSSING_CTRL_FLASH_EN
                S_FLASH: begin
                    if (!modeEff) begin
                        stateNext = S_CLEAR;
                        cntNext   = LD_CLEAR;
                        firstNext = 1'b1;
                    end else begin
                        flashNext = ~flash;
                    end
                end
`endif
                default: begin
                    stateNext = S_CLEAR;
                    cntNext   = LD_CLEAR;
                end
            endcase
        end
    end

    // Registered output decode of the current state
    always_comb begin
        lightNext = '0;
        walkNext  = '0;
        for (int k = 0; k < C_PHASES; k++) begin
            lightNext[2*k +: 2] = L_RED;
            if (state == S_GREEN && phase == 2'(k))
                lightNext[2*k +: 2] = L_GRN;
            if (state == S_YELLOW && phase == 2'(k))
                lightNext[2*k +: 2] = L_YEL;
`ifdef CROSSING_CTRL_FLASH_EN
            if (state == S_FLASH)
                lightNext[2*k +: 2] = flash ? L_YEL : L_OFF;
`endif
        end
        if (state == S_WALK)
            walkNext = walkSnap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_CLEAR;
            cnt        <= LD_CLEAR;
            phase      <= 2'd0;
            first      <= 1'b1;
            pedPrev    <= '0;
            outPending <= '0;
            walkSnap   <= '0;
            outLight   <= {C_PHASES{L_RED}};
            outWalk    <= '0;
            outPhase   <= 2'd0;
`ifdef CROSSING_CTRL_FLASH_EN
            flash      <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            phase      <= phaseNext;
            first      <= firstNext;
            pedPrev    <= inPedestrian;
            outPending <= pendNext;
            walkSnap   <= snapNext;
            outLight   <= lightNext;
            outWalk    <= walkNext;
            outPhase   <= phase;
`ifdef CROSSING_CTRL_FLASH_EN
            flash      <= flashNext;
`endif
        end
    end

endmodule

// File: tb/tb_crossing_ctrl.sv
// tb_crossing_ctrl: directed checks of crossing_ctrl cycle, walk and night mode.
// Night-mode checks follow CROSSING_CTRL_FLASH_EN; otherwise inMode must be ignored.
module tb_crossing_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inTick = 1'b0;
    logic       inMode = 1'b0;
    logic [1:0] inPedestrian = 2'b00;
    logic [3:0] outLight;
    logic [1:0] outWalk;
    logic [1:0] outPhase;
    logic [1:0] outPending;

    int total = 0;
    int bad   = 0;

    crossing_ctrl #(
        .C_PHASES(2), .C_INT_GREEN(3), .C_INT_YELLOW(1),
        .C_INT_CLEAR(1), .C_INT_WALK(2), .C_CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .inTick(inTick), .inMode(inMode),
        .inPedestrian(inPedestrian), .outLight(outLight),
        .outWalk(outWalk), .outPhase(outPhase), .outPending(outPending)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ALL_RED = 4'b0101;
    localparam logic [3:0] G0      = 4'b0110;
    localparam logic [3:0] Y0      = 4'b0111;
    localparam logic [3:0] G1      = 4'b1001;
    localparam logic [3:0] Y1      = 4'b1101;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One strobe, then one more edge so the registered outputs catch up
    task automatic doTick();
        @(negedge clk) inTick = 1'b1;
        @(negedge clk) inTick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) doTick();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        check("rstLight", 8'(outLight), 8'(ALL_RED));
        check("rstPhase", 8'(outPhase), 8'd0);
        check("rstWalk", 8'(outWalk), 8'd0);
        check("rstPend", 8'(outPending), 8'd0);

        doTick();
        check("g0", 8'(outLight), 8'(G0));
        check("g0Ph", 8'(outPhase), 8'd0);
        ticks(2);
        check("g0Hold", 8'(outLight), 8'(G0));
        doTick();
        check("y0", 8'(outLight), 8'(Y0));
        doTick();
        check("clr0", 8'(outLight), 8'(ALL_RED));
        doTick();
        check("g1", 8'(outLight), 8'(G1));
        check("g1Ph", 8'(outPhase), 8'd1);
        ticks(2);
        check("g1Hold", 8'(outLight), 8'(G1));
        doTick();
        check("y1", 8'(outLight), 8'(Y1));
        doTick();
        check("clr1", 8'(outLight), 8'(ALL_RED));
        doTick();
        check("wrapG0", 8'(outLight), 8'(G0));
        check("wrapPh", 8'(outPhase), 8'd0);

        // Pedestrian pulse on phase 1 during phase 0 green
        @(negedge clk) inPedestrian = 2'b10;
        @(negedge clk) inPedestrian = 2'b00;
        check("pedLatch", 8'(outPending), 8'b10);
        ticks(4);
        check("pedClr", 8'(outLight), 8'(ALL_RED));
        doTick();
        check("walkOn", 8'(outWalk), 8'b10);
        check("walkRed", 8'(outLight), 8'(ALL_RED));
        check("walkPend", 8'(outPending), 8'd0);
        doTick();
        check("walkHold", 8'(outWalk), 8'b10);
        doTick();
        check("postWalk", 8'(outLight), 8'(G1));
        check("postWalkW", 8'(outWalk), 8'd0);
        check("postWalkPh", 8'(outPhase), 8'd1);

        // Held button across a walk, then a fresh press during it
        @(negedge clk) inPedestrian = 2'b01;
        @(negedge clk);
        check("heldLatch", 8'(outPending), 8'b01);
        ticks(5);
        check("heldWalk", 8'(outWalk), 8'b01);
        check("heldPend", 8'(outPending), 8'd0);
        @(negedge clk) inPedestrian = 2'b00;
        @(negedge clk) inPedestrian = 2'b01;
        @(negedge clk);
        check("rePress", 8'(outPending), 8'b01);
        doTick();
        check("reWalk", 8'(outWalk), 8'b01);
        doTick();
        check("reG0", 8'(outLight), 8'(G0));
        check("reKeep", 8'(outPending), 8'b01);
        inPedestrian = 2'b00;
        ticks(5);
        check("secondWalk", 8'(outWalk), 8'b01);
        check("secondPend", 8'(outPending), 8'd0);
        ticks(2);
        check("secondG1", 8'(outLight), 8'(G1));

        // Night mode raised on the first green tick
        inMode = 1'b1;
`ifdef CROSSING_CTRL_FLASH_EN
        doTick();
        check("nYel", 8'(outLight), 8'(Y1));
        doTick();
        check("nClr", 8'(outLight), 8'(ALL_RED));
        doTick();
        check("flashOn", 8'(outLight), 8'b1111);
        doTick();
        check("flashOff", 8'(outLight), 8'b0000);
        doTick();
        check("flashOn2", 8'(outLight), 8'b1111);
        inMode = 1'b0;
        doTick();
        check("fExitClr", 8'(outLight), 8'(ALL_RED));
        doTick();
        check("fExitG0", 8'(outLight), 8'(G0));
        check("fExitPh", 8'(outPhase), 8'd0);
`else
        doTick();
        check("nIgnG1", 8'(outLight), 8'(G1));
        doTick();
        check("nIgnG1b", 8'(outLight), 8'(G1));
        doTick();
        check("nIgnY1", 8'(outLight), 8'(Y1));
        doTick();
        check("nIgnClr", 8'(outLight), 8'(ALL_RED));
        inMode = 1'b0;
        doTick();
        check("nIgnG0", 8'(outLight), 8'(G0));
        check("nIgnPh", 8'(outPhase), 8'd0);
`endif

        // Async reset in the middle of phase 0 yellow
        @(negedge clk) inPedestrian = 2'b01;
        @(negedge clk) inPedestrian = 2'b00;
        ticks(3);
        check("preRstY", 8'(outLight), 8'(Y0));
        check("preRstPend", 8'(outPending), 8'b01);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arstLight", 8'(outLight), 8'(ALL_RED));
        check("arstWalk", 8'(outWalk), 8'd0);
        check("arstPend", 8'(outPending), 8'd0);
        @(negedge clk) rst = 1'b0;
        doTick();
        check("arstG0", 8'(outLight), 8'(G0));
        check("arstPh", 8'(outPhase), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
